// File: rtl/tft_spi_arbiter.sv
// Round-robin arbiter sharing one tft_spi byte transmitter among N_REQ requesters.
// Owners hand over only through DRAIN, so a byte in flight always completes first.
module tft_spi_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_dc,
    input  logic [N_REQ-1:0]     req_transmit,
    input  logic                 spi_busy,
    output logic [7:0]           spi_data,
    output logic                 spi_dc,
    output logic                 spi_transmit,
    output logic [N_REQ-1:0]     grant,
    output logic                 timeout_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]       state_r;
    logic [N_REQ-1:0] grant_r;
    logic [N_REQ-1:0] mask_r;
    logic [IW-1:0]    ptr_r;
    logic [15:0]      cnt_r;
    logic             timeout_err_r;

    logic [N_REQ-1:0] eligible_s;
    logic [N_REQ-1:0] sel_onehot_s;
    logic [IW-1:0]    sel_s;
    logic [IW-1:0]    ptr_next_s;
    logic             found_s;
    logic             owner_req_s;
    logic             activity_s;
    logic             expire_s;

    // Round-robin search over unmasked requests, starting at ptr_r
    always_comb begin
        int idx;
        eligible_s   = req & ~mask_r;
        found_s      = 1'b0;
        sel_s        = {IW{1'b0}};
        sel_onehot_s = {N_REQ{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_r) + k;
            idx = (idx >= N_REQ) ? idx - N_REQ : idx;
            if (!found_s && eligible_s[idx]) begin
                found_s           = 1'b1;
                sel_s             = IW'(idx);
                sel_onehot_s[idx] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        ptr_next_s = (sel_s == IW'(N_REQ - 1)) ? {IW{1'b0}} : sel_s + IW'(1);
    end

    // Route the owner's byte, dc and strobe; grant_r is zero outside GRANT
    always_comb begin
        spi_data     = 8'h00;
        spi_dc       = 1'b0;
        spi_transmit = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (state_r == GRANT && grant_r[i]) begin
                spi_data     = spi_data | req_data[8*i +: 8];
                spi_dc       = spi_dc | req_dc[i];
                spi_transmit = spi_transmit | req_transmit[i];
            end else begin
                spi_data = spi_data;
            end
        end
    end

    // Ownership status and idle-timeout detection
    always_comb begin
        owner_req_s = |(req & grant_r);
        activity_s  = spi_transmit | spi_busy;
        expire_s    = (state_r == GRANT) && !activity_s && (cnt_r == TO_LAST);
    end

    // Arbitration state machine, timeout counter and requester masking
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            grant_r       <= {N_REQ{1'b0}};
            mask_r        <= {N_REQ{1'b0}};
            ptr_r         <= {IW{1'b0}};
            cnt_r         <= 16'd0;
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= 1'b0;
            // A mask bit only survives while its requester keeps req high
            mask_r        <= mask_r & req;
            case (state_r)
                IDLE: begin
                    cnt_r <= 16'd0;
                    if (found_s) begin
                        state_r <= GRANT;
                        grant_r <= sel_onehot_s;
                        ptr_r   <= ptr_next_s;
                    end else begin
                        grant_r <= {N_REQ{1'b0}};
                    end
                end
                GRANT: begin
                    if (expire_s) begin
                        state_r       <= DRAIN;
                        grant_r       <= {N_REQ{1'b0}};
                        timeout_err_r <= 1'b1;
                        mask_r        <= (mask_r | grant_r) & req;
                        cnt_r         <= 16'd0;
                    end else if (!owner_req_s) begin
                        state_r <= DRAIN;
                        grant_r <= {N_REQ{1'b0}};
                        cnt_r   <= 16'd0;
                    end else if (activity_s) begin
                        cnt_r <= 16'd0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                DRAIN: begin
                    grant_r <= {N_REQ{1'b0}};
                    if (!spi_busy) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= {N_REQ{1'b0}};
                    cnt_r   <= 16'd0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_tft_spi_arbiter.sv
// Directed table-driven bench for tft_spi_arbiter (N_REQ=3, TIMEOUT=16).
// Each record applies inputs, waits one rising edge, then checks all outputs.
`timescale 1ns/1ps
module tb_tft_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  req_dc;
    logic [2:0]  req_transmit;
    logic        spi_busy;
    logic [7:0]  spi_data;
    logic        spi_dc;
    logic        spi_transmit;
    logic [2:0]  grant;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] dc;
        logic [2:0] tx;
        logic       busy;
        logic [2:0] g;
        logic [7:0] d;
        logic       edc;
        logic       etx;
        logic       terr;
    } vec_t;

    vec_t vecs[$];

    tft_spi_arbiter #(.N_REQ(3), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_dc(req_dc),
        .req_transmit(req_transmit),
        .spi_busy(spi_busy),
        .spi_data(spi_data),
        .spi_dc(spi_dc),
        .spi_transmit(spi_transmit),
        .grant(grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [2:0] q, input logic [2:0] dc,
                       input logic [2:0] tx, input logic b, input logic [2:0] g,
                       input logic [7:0] d, input logic edc, input logic etx,
                       input logic terr);
        vec_t v;
        v.rst = r; v.req = q; v.dc = dc; v.tx = tx; v.busy = b;
        v.g = g; v.d = d; v.edc = edc; v.etx = etx; v.terr = terr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst          = 1'b0;
        req          = 3'b000;
        req_data     = {8'h5A, 8'hA5, 8'h11};
        req_dc       = 3'b000;
        req_transmit = 3'b000;
        spi_busy     = 1'b0;

        // Round-robin walk 0 -> 1 -> 2 with a DRAIN and IDLE cycle between owners
        add(1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 3'b001, 8'h11, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 3'b010, 8'hA5, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b100, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b100, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b100, 3'b000, 3'b000, 1'b0, 3'b100, 8'h5A, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        // Requester 1 sends 0xA5 dc=1; requester 2's strobe must not leak through
        add(1'b1, 3'b010, 3'b010, 3'b110, 1'b0, 3'b010, 8'hA5, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3'b010, 3'b000, 3'b100, 1'b0, 3'b010, 8'hA5, 1'b0, 1'b0, 1'b0);
        // Owner drops req with busy high for 8 cycles; others requesting meanwhile
        add(1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++)
            add(1'b1, 3'b101, 3'b000, 3'b000, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b101, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b101, 3'b000, 3'b000, 1'b0, 3'b100, 8'h5A, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        // Idle owner 0 times out 16 cycles after grant, then stays masked
        add(1'b1, 3'b001, 3'b000, 3'b000, 1'b0, 3'b001, 8'h11, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++)
            add(1'b1, 3'b001, 3'b000, 3'b000, 1'b0, 3'b001, 8'h11, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1);
        add(1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 3'b010, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            add(1'b1, 3'b001, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b001, 3'b000, 3'b000, 1'b0, 3'b001, 8'h11, 1'b0, 1'b0, 1'b0);
        // Reset during a busy grant to requester 1; pointer restarts at index 0
        add(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b010, 3'b000, 3'b000, 1'b0, 3'b010, 8'hA5, 1'b0, 1'b0, 1'b0);
        add(1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 3'b010, 8'hA5, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst          = vecs[i].rst;
            req          = vecs[i].req;
            req_dc       = vecs[i].dc;
            req_transmit = vecs[i].tx;
            spi_busy     = vecs[i].busy;
            @(posedge clk);
            #1;
            check("grant", i, {5'b00000, grant}, {5'b00000, vecs[i].g});
            check("spi_data", i, spi_data, vecs[i].d);
            check("spi_dc", i, {7'b0000000, spi_dc}, {7'b0000000, vecs[i].edc});
            check("spi_transmit", i, {7'b0000000, spi_transmit}, {7'b0000000, vecs[i].etx});
            check("timeout_err", i, {7'b0000000, timeout_err}, {7'b0000000, vecs[i].terr});
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
